// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack port, holds the instruction for one EXEC cycle.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (halt on a misaligned next PC instead of clearing its low bits).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        halted,
  output logic        fetch_err,
  output logic        misalign,
  output logic [1:0]  dbg_state
);

  // Handshake: imem_req is high for every REQ cycle; a cycle with imem_req && imem_ack
  // transfers imem_rdata, and imem_ack in any other cycle is ignored.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic        err_q, err_d;
  logic [31:0] target;
  logic [31:0] next_pc;

  assign wait_inc = wait_q + 8'd1;

  always_comb begin
    target = pc_q + 32'd4;
    case (PCSrc)
      2'b01:   target = pc_q + ImmExt;
      2'b10:   target = {ALUResult[31:1], 1'b0};
      default: target = pc_q + 32'd4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign next_pc  = target;
  assign misalign = mis_q;
`else
  assign next_pc  = target & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    err_d   = err_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      S_REQ: begin
        // An ack arriving on the limit cycle still completes the fetch.
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = 8'd0;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_EXEC: begin
        if (done) begin
          state_d = S_HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
        end else if (|next_pc[1:0]) begin
          mis_d   = 1'b1;
          state_d = S_HALT;
`endif
        end else begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == S_REQ);
    instr_valid = (state_q == S_EXEC);
    halted      = (state_q == S_HALT);
    dbg_state   = state_q;
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign PCPlus4   = pc_q + 32'd4;
  assign Instr     = instr_q;
  assign op        = instr_q[6:0];
  assign func3     = instr_q[14:12];
  assign func7     = instr_q[31:25];
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized fetch/execute traffic against a PC-sequence reference model.
module tb_fetch_unit;

  localparam int          MW      = 4;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ImmExt = '0;
  logic [31:0] ALUResult = '0;
  logic        done = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        halted;
  logic        fetch_err;
  logic        misalign;
  logic [1:0]  dbg_state;

  fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .done(done), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Instr(Instr), .op(op), .func3(func3), .func7(func7),
    .instr_valid(instr_valid), .PC(PC), .PCPlus4(PCPlus4), .halted(halted),
    .fetch_err(fetch_err), .misalign(misalign), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: exp_q[0] is the address the next fetch (or the halted PC) must show.
  logic [31:0] exp_q[$];
  logic [31:0] exp_instr;
  bit          exp_halt, exp_err, exp_mis;

  function automatic logic [31:0] model_next(logic [31:0] pc, logic [1:0] src,
                                             logic [31:0] imm, logic [31:0] alu);
    logic [31:0] t;
    if (src == 2'd1)      t = pc + imm;
    else if (src == 2'd2) t = alu - (alu % 2);
    else                  t = pc + 4;
`ifndef FETCH_MISALIGN_TRAP_EN
    t = t - (t % 4);
`endif
    return t;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RST_PC);
    exp_instr = NOP;
    exp_halt  = 0;
    exp_err   = 0;
    exp_mis   = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    imem_ack = 0;
    done     = 0;
    rst      = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  // One instruction: k wait cycles, ack, then an EXEC cycle with the given controller inputs.
  task automatic run_instr(input int k, input logic [31:0] rdata, input logic [1:0] src,
                           input logic [31:0] imm, input logic [31:0] alu, input logic dn);
    logic [31:0] addr, np;
    addr = exp_q.pop_front();
    for (int j = 0; j <= k; j++) begin
      total_cnt++;
      if ({imem_req, instr_valid, halted} !== 3'b100 || imem_addr !== addr || PC !== addr ||
          Instr !== exp_instr)
        $display("FAIL req_phase: req=%b valid=%b halted=%b addr=%h pc=%h instr=%h, required req=1 valid=0 halted=0 addr=%h instr=%h",
                 imem_req, instr_valid, halted, imem_addr, PC, Instr, addr, exp_instr);
      else pass_cnt++;
      imem_ack   = (j == k);
      imem_rdata = (j == k) ? rdata : $urandom;
      PCSrc      = 2'($urandom_range(0, 3));
      done       = 1'($urandom_range(0, 1));
      @(negedge clk);
      imem_ack = 0;
      done     = 0;
      if (j < k && j + 1 == MW) begin
        exp_halt = 1;
        exp_err  = 1;
        exp_q.push_back(addr);
        return;
      end
    end
    exp_instr = rdata;
    total_cnt++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || halted !== 1'b0 || Instr !== rdata ||
        op !== rdata[6:0] || func3 !== rdata[14:12] || func7 !== rdata[31:25] ||
        PC !== addr || PCPlus4 !== addr + 32'd4)
      $display("FAIL exec_phase: valid=%b req=%b instr=%h op=%h f3=%h f7=%h pc=%h pc4=%h, required valid=1 req=0 instr=%h pc=%h",
               instr_valid, imem_req, Instr, op, func3, func7, PC, PCPlus4, rdata, addr);
    else pass_cnt++;
    PCSrc      = src;
    ImmExt     = imm;
    ALUResult  = alu;
    done       = dn;
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    @(negedge clk);
    done      = 0;
    imem_ack  = 0;
    PCSrc     = 2'($urandom_range(0, 3));
    ImmExt    = $urandom;
    ALUResult = $urandom;
    np = model_next(addr, src, imm, alu);
    if (dn) begin
      exp_halt = 1;
      exp_q.push_back(addr);
    end else if (np % 4 != 0) begin
      exp_halt = 1;
      exp_mis  = 1;
      exp_q.push_back(addr);
    end else begin
      exp_q.push_back(np);
    end
  endtask

  task automatic check_halted(input int cycles, input string name);
    for (int j = 0; j < cycles; j++) begin
      total_cnt++;
      if ({imem_req, instr_valid, halted, fetch_err, misalign} !== {3'b001, exp_err, exp_mis} ||
          PC !== exp_q[0] || Instr !== exp_instr)
        $display("FAIL %s: req=%b valid=%b halted=%b err=%b mis=%b pc=%h instr=%h, required req=0 valid=0 halted=1 err=%b mis=%b pc=%h instr=%h",
                 name, imem_req, instr_valid, halted, fetch_err, misalign, PC, Instr,
                 exp_err, exp_mis, exp_q[0], exp_instr);
      else pass_cnt++;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      done       = 1'($urandom_range(0, 1));
      PCSrc      = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    imem_ack = 0;
    done     = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total_cnt++;
    if ({imem_req, instr_valid, halted, fetch_err, misalign} !== 5'b10000 || PC !== RST_PC ||
        imem_addr !== RST_PC || PCPlus4 !== RST_PC + 32'd4 || Instr !== NOP)
      $display("FAIL reset_values: req=%b valid=%b halted=%b err=%b mis=%b pc=%h addr=%h instr=%h, required 1 0 0 0 0 pc=%h instr=%h",
               imem_req, instr_valid, halted, fetch_err, misalign, PC, imem_addr, Instr, RST_PC, NOP);
    else pass_cnt++;
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) run_instr(0, $urandom, 2'b00, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_wait();
    run_instr(3, $urandom, 2'b00, '0, '0, 1'b0);
    run_instr(1, $urandom, 2'b11, $urandom, $urandom, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(0, $urandom, 2'b10, '0, 32'h0000_0010, 1'b0);
    run_instr(0, $urandom, 2'b01, 32'hFFFF_FFF8, '0, 1'b0);
    run_instr(0, $urandom, 2'b10, '0, 32'h0000_0101, 1'b0);
    run_instr(0, $urandom, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, MW - 1), $urandom, 2'($urandom_range(0, 3)),
                $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD, 1'b0);
  endtask

  task automatic test_misalign();
    run_instr(0, $urandom, 2'b01, 32'h0000_0002, '0, 1'b0);
    if (exp_halt) begin
      check_halted(3, "misalign_halt");
      apply_reset();
    end else begin
      run_instr(0, $urandom, 2'b10, '0, 32'h0000_0007, 1'b0);
      run_instr(0, $urandom, 2'b00, '0, '0, 1'b0);
    end
  endtask

  task automatic test_done();
    run_instr(0, $urandom, 2'b10, '0, 32'h0000_0020, 1'b0);
    run_instr(1, $urandom, 2'b01, 32'h0000_0100, '0, 1'b1);
    check_halted(5, "done_halt");
    apply_reset();
  endtask

  task automatic test_timeout();
    run_instr(0, $urandom, 2'b00, '0, '0, 1'b0);
    run_instr(MW + 2, $urandom, 2'b00, '0, '0, 1'b0);
    check_halted(4, "timeout_halt");
    apply_reset();
  endtask

  task automatic test_ack_at_limit();
    run_instr(MW - 1, $urandom, 2'b00, '0, '0, 1'b0);
    total_cnt++;
    if (halted !== 1'b0 || fetch_err !== 1'b0)
      $display("FAIL ack_at_limit: halted=%b err=%b, required halted=0 err=0", halted, fetch_err);
    else pass_cnt++;
    run_instr(MW - 1, $urandom, 2'b10, '0, 32'h0000_0040, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    imem_ack = 0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    #1;
    total_cnt++;
    if (imem_req !== 1'b1 || PC !== RST_PC || Instr !== NOP || instr_valid !== 1'b0 ||
        halted !== 1'b0)
      $display("FAIL reset_mid_wait: req=%b pc=%h instr=%h valid=%b halted=%b, required req=1 pc=%h instr=%h valid=0 halted=0",
               imem_req, PC, Instr, instr_valid, halted, RST_PC, NOP);
    else pass_cnt++;
    @(negedge clk);
    rst = 1;
    model_reset();
    run_instr(MW - 1, $urandom, 2'b00, '0, '0, 1'b0);
    run_instr(0, $urandom, 2'b00, '0, '0, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_wait();
    test_branch();
    test_random();
    test_misalign();
    test_done();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core.
- Owns the program counter and fetches each instruction over a request/acknowledge instruction-memory port.
- Presents the decoded opcode fields to the controller for exactly one execute cycle.
- Computes the next PC from the controller's `PCSrc`, `ImmExt` and `ALUResult`.
- Stops permanently when the controller raises `done`.

## Interface
Parameters:
- `RESET_PC`, 32'h00000000, PC value loaded at reset.
- `MAX_WAIT`, 255, maximum `REQ` cycles without `imem_ack` before a fetch error; 1..255.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `PCSrc`  in  2  00 = PC+4, 01 = PC+ImmExt, 10 = jalr target, 11 = reserved (treated as PC+4).
- `ImmExt`  in  32  sign-extended branch/jal offset.
- `ALUResult`  in  32  jalr target address.
- `done`  in  1  controller halt request.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, always equals `PC`.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `Instr`  out  32  held instruction register.
- `op`  out  7  `Instr[6:0]`.
- `func3`  out  3  `Instr[14:12]`.
- `func7`  out  7  `Instr[31:25]`.
- `instr_valid`  out  1  high only in the `EXEC` state.
- `PC`  out  32  current PC.
- `PCPlus4`  out  32  `PC`+4, the link value.
- `halted`  out  1  in the `HALT` state.
- `fetch_err`  out  1  halted due to timeout.
- `misalign`  out  1  halted due to misaligned target; tied 0 without the macro.

## Operation
The FSM has three states: `REQ`, `EXEC` and `HALT`.

Reset values:
- state = `REQ`, `PC` = `RESET_PC`, `Instr` = 32'h00000013 (nop), wait counter = 0.
- `fetch_err` = 0, `misalign` = 0.
- `instr_valid` = 0, `halted` = 0.
- `imem_req` = 1 combinationally from the `REQ` state.

`REQ` state:
- `imem_req` = 1, `imem_addr` = `PC`.
- On `imem_ack`: latch `imem_rdata` into `Instr`, clear the counter, go to `EXEC`.
- Otherwise increment the counter. When the counter equals `MAX_WAIT`, set `fetch_err` and go to `HALT`.
- `imem_ack` in the same cycle as the limit is reached wins: the fetch succeeds.

`EXEC` state:
- `instr_valid` = 1, `imem_req` = 0.
- The controller decodes `op`/`func3`/`func7` combinationally in this cycle.
- If `done` = 1: go to `HALT`; `PC` is unchanged.
- Otherwise load `PC` with next_pc and return to `REQ`.

`HALT` state:
- Terminal; leave only via `rst`.
- `halted` = 1, `imem_req` = 0, `instr_valid` = 0.

next_pc:
- PC+4, PC+ImmExt, or {ALUResult[31:1], 1'b0} per `PCSrc`.
- 32-bit modular arithmetic; wraps silently at 2^32.

Other rules:
- `imem_ack` outside `REQ` is ignored; `Instr` does not change.
- `done`, `PCSrc`, `ImmExt` and `ALUResult` are sampled only in `EXEC`.
- Reset asserted in any state returns immediately to reset values; an outstanding request is abandoned.

## Timing
- Ack in the first `REQ` cycle: 2 cycles per instruction (`REQ`, `EXEC`). Ack after k wait cycles: k+2 cycles.
- `Instr`/`op`/`func3`/`func7` are registered outputs and stable for the whole `EXEC` cycle.
- `PC` updates on the edge ending `EXEC`; the new `imem_addr` is visible in the following `REQ` cycle.
- The `fetch_err` or `misalign` flag and `halted` assert in the cycle after the triggering edge, and both stay set.

## Configuration
`FETCH_MISALIGN_TRAP_EN`:
- Defined: in `EXEC` with `done` = 0, if `next_pc[1:0]` != 0 then `PC` is unchanged, `misalign` is set, and the FSM goes to `HALT`.
- Undefined: `next_pc[1:0]` is forced to 00 and execution continues; `misalign` is constant 0.

## Test plan
- Reset with `RESET_PC` = 0 and ack on every request -> `imem_addr` 0, 4, 8; `instr_valid` high every 2nd cycle; `PC` increments by 4.
- Ack delayed 3 cycles -> `imem_req` held 4 cycles at the same address; `EXEC` begins one cycle after ack; `PC` unchanged during the wait.
- `EXEC` at `PC` 0x10 with `PCSrc` = 01, `ImmExt` = 0xFFFFFFF8 -> next fetch at 0x08. `PCSrc` = 10, `ALUResult` = 0x101 -> next fetch at 0x100.
- `done` = 1 in `EXEC` at `PC` 0x20 -> `halted` = 1, `PC` stays 0x20, no further `imem_req`, late `imem_ack` ignored.
- `MAX_WAIT` = 4, no ack -> `fetch_err` = 1 and `halted` = 1 after 4 `REQ` cycles. Repeat with ack on the 4th cycle -> no error, `EXEC` follows.
- With the macro defined, `PCSrc` = 01 and `ImmExt` = 2 -> `misalign` = 1, `halted` = 1. Without the macro -> next fetch at `PC`+0 (low bits cleared). Reset asserted mid-wait -> `PC` = `RESET_PC` and `imem_req` restarts.
